// File: rtl/dual_update_stream_pkg.sv
// Shared types and helpers for the streaming ADMM dual updater.
// Defines the default word type, the FSM state encoding and a generic saturate helper.
package dual_pkg;

  localparam int DUAL_W = 16;

  typedef logic signed [DUAL_W-1:0] dual_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } dual_state_e;

  // Clamp a wide signed value into the signed range of a w-bit word.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input int unsigned w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 32'd1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 32'd1));
    if (v > hi) begin
      saturate = hi;
    end else if (v < lo) begin
      saturate = lo;
    end else begin
      saturate = v;
    end
  endfunction

endpackage

// File: rtl/dual_update_stream_if.sv
// Beat-level input/output stream bundle for dual_update_stream.
// slave is the updater's view, master the producer/consumer view.
interface dual_update_stream_if #(
  parameter int W     = 16,
  parameter int LANES = 4
);
  logic                        in_valid;
  logic                        in_ready;
  logic [LANES-1:0][W-1:0]     in_a;
  logic [LANES-1:0][W-1:0]     in_b;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES-1:0][W-1:0]     out_dual;
  logic                        out_last;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_dual, out_last
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_dual, out_last
  );
endinterface

// File: rtl/dual_update_stream_lane.sv
// One lane of the dual update: S1 holds a-b and the stored dual, S2 holds sat(y + step).
// With DUAL_UPDATE_RHO_EN the step is (rho*d)>>>FRAC, computed between S1 and S2.
module dual_update_stream_lane
  import dual_pkg::*;
#(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic                clk,
  input  logic                reset,
`ifdef DUAL_UPDATE_RHO_EN
  input  logic [W-1:0]        rho,
`endif
  input  logic                ld1,
  input  logic                ld2,
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] y,
  output logic signed [W-1:0] nxt,
  output logic signed [W-1:0] q,
  output logic [W:0]          abs_d
);

  logic signed [W:0]   d_r;
  logic signed [W-1:0] y_r;
  logic signed [W-1:0] q_r;
  logic signed [63:0]  step_s;
  logic signed [63:0]  sum_s;
`ifdef DUAL_UPDATE_RHO_EN
  logic signed [2*W+1:0] prod_s;
  logic signed [2*W:0]   prod_trim_s;
`endif

  // S1: capture the difference at full precision and the dual being updated
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      d_r <= '0;
      y_r <= '0;
    end else if (ld1) begin
      d_r <= {a[W-1], a} - {b[W-1], b};
      y_r <= y;
    end
  end

  // Step and saturated sum between S1 and S2
  always_comb begin
`ifdef DUAL_UPDATE_RHO_EN
    prod_s      = (2*W+2)'($signed({1'b0, rho})) * (2*W+2)'(d_r);
    prod_trim_s = prod_s[2*W:0];
    step_s      = 64'(prod_trim_s) >>> FRAC;
`else
    step_s      = 64'(d_r);
`endif
    sum_s = step_s + 64'(y_r);
    nxt   = W'(saturate(sum_s, W));
  end

  // S2: present the updated dual
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= '0;
    end else if (ld2) begin
      q_r <= nxt;
    end
  end

  assign q     = q_r;
  assign abs_d = d_r[W] ? $unsigned(-d_r) : $unsigned(d_r);

endmodule

// File: rtl/dual_update_stream.sv
// Streaming ADMM dual updater: register file of duals, beat FSM, 2-stage lane pipeline, residual max.
// Optional DUAL_UPDATE_RHO_EN adds the rho port and scales each step by rho.
module dual_update_stream
  import dual_pkg::*;
#(
  parameter int W         = 16,
  parameter int FRAC      = 8,
  parameter int LANES     = 4,
  parameter int NUM_ELEMS = 72
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  clear_duals,
`ifdef DUAL_UPDATE_RHO_EN
  input  logic [W-1:0]          rho,
`endif
  dual_update_stream_if.slave   bus,
  output logic [W-1:0]          resid_max,
  output logic                  busy,
  output logic                  done
);

  localparam int BEATS = NUM_ELEMS / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_RUN   = RUN;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]          state_r;
  logic [CW-1:0]       in_cnt_r;
  logic [CW-1:0]       s1_cnt_r;
  logic                s1_valid_r;
  logic                s1_last_r;
  logic                s2_valid_r;
  logic                s2_last_r;
  logic [W:0]          acc_r;
  logic [W-1:0]        resid_max_r;
  logic                done_r;
  logic signed [W-1:0] mem_r [NUM_ELEMS];

  logic                adv_s;
  logic                accept_s;
  logic                ld2_s;
  logic                clr_s;
  logic [W:0]          bmax_s;
  logic [AW-1:0]       rd_idx_s [LANES];
  logic [AW-1:0]       wr_idx_s [LANES];
  logic signed [W-1:0] y_in_s   [LANES];
  logic signed [W-1:0] nxt_s    [LANES];
  logic signed [W-1:0] q_s      [LANES];
  logic [W:0]          abs_s    [LANES];

  // The whole pipeline moves together; it only stops when S2 holds an unaccepted beat.
  assign adv_s        = !s2_valid_r || bus.out_ready;
  assign bus.in_ready = (state_r == ST_RUN) && adv_s;
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign ld2_s        = adv_s && s1_valid_r;
  assign clr_s        = (state_r == ST_IDLE) && clear_duals;

  // Register-file addressing, read data and the per-beat residual reduction
  always_comb begin
    bmax_s = acc_r;
    for (int j = 0; j < LANES; j++) begin
      rd_idx_s[j] = AW'(int'(in_cnt_r) * LANES + j);
      wr_idx_s[j] = AW'(int'(s1_cnt_r) * LANES + j);
      y_in_s[j]   = mem_r[rd_idx_s[j]];
      if (abs_s[j] > bmax_s) begin
        bmax_s = abs_s[j];
      end else begin
        bmax_s = bmax_s;
      end
    end
  end

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    dual_update_stream_lane #(.W(W), .FRAC(FRAC)) u_lane (
      .clk   (clk),
      .reset (reset),
`ifdef DUAL_UPDATE_RHO_EN
      .rho   (rho),
`endif
      .ld1   (accept_s),
      .ld2   (ld2_s),
      .a     ($signed(bus.in_a[j])),
      .b     ($signed(bus.in_b[j])),
      .y     (y_in_s[j]),
      .nxt   (nxt_s[j]),
      .q     (q_s[j]),
      .abs_d (abs_s[j])
    );
    assign bus.out_dual[j] = q_s[j];
  end

  // Dual register file: bulk clear in IDLE, otherwise write back as S2 loads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int e = 0; e < NUM_ELEMS; e++) begin
        mem_r[e] <= '0;
      end
    end else if (clr_s) begin
      for (int e = 0; e < NUM_ELEMS; e++) begin
        mem_r[e] <= '0;
      end
    end else if (ld2_s) begin
      for (int j = 0; j < LANES; j++) begin
        mem_r[wr_idx_s[j]] <= nxt_s[j];
      end
    end
  end

  // Pipeline valid/last/beat-index tracking
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_cnt_r   <= '0;
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
    end else if (adv_s) begin
      s1_valid_r <= accept_s;
      s1_last_r  <= accept_s && (in_cnt_r == LAST_BEAT);
      if (accept_s) begin
        s1_cnt_r <= in_cnt_r;
      end
      s2_valid_r <= s1_valid_r;
      s2_last_r  <= s1_valid_r && s1_last_r;
    end
  end

  // Iteration FSM, input beat counter, residual accumulator and latched status
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      in_cnt_r    <= '0;
      acc_r       <= '0;
      resid_max_r <= '0;
      done_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (ld2_s) begin
        acc_r <= bmax_s;
      end
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r  <= ST_RUN;
            in_cnt_r <= '0;
            acc_r    <= '0;
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            if (in_cnt_r == LAST_BEAT) begin
              in_cnt_r <= '0;
              state_r  <= ST_DRAIN;
            end else begin
              in_cnt_r <= in_cnt_r + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (s2_valid_r && s2_last_r && bus.out_ready) begin
            state_r     <= ST_IDLE;
            done_r      <= 1'b1;
            resid_max_r <= W'(saturate($signed(64'(acc_r)), W));
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.out_valid = s2_valid_r;
  assign bus.out_last  = s2_last_r;
  assign resid_max     = resid_max_r;
  assign done          = done_r;
  assign busy          = (state_r == ST_RUN) || (state_r == ST_DRAIN);

endmodule

// File: tb/tb_dual_update_stream.sv
// Randomized self-checking bench for dual_update_stream against an element-level dual model.
// Works with and without DUAL_UPDATE_RHO_EN.
module tb_dual_update_stream;

  localparam int W         = 16;
  localparam int FRAC      = 8;
  localparam int LANES     = 4;
  localparam int NUM_ELEMS = 8;
  localparam int BEATS     = NUM_ELEMS / LANES;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic clear_duals = 1'b0;
`ifdef DUAL_UPDATE_RHO_EN
  logic [W-1:0] rho = 16'h0100;
`endif
  logic [W-1:0] resid_max;
  logic busy;
  logic done;

  dual_update_stream_if #(.W(W), .LANES(LANES)) bus ();

  dual_update_stream #(.W(W), .FRAC(FRAC), .LANES(LANES), .NUM_ELEMS(NUM_ELEMS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .clear_duals (clear_duals),
`ifdef DUAL_UPDATE_RHO_EN
    .rho         (rho),
`endif
    .bus         (bus.slave),
    .resid_max   (resid_max),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  int mdl   [NUM_ELEMS];
  int sa    [NUM_ELEMS];
  int sb    [NUM_ELEMS];
  int exp_d [NUM_ELEMS];
  int got_d [NUM_ELEMS];
  int exp_res;

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sat_w(input longint v);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Reference: every element is y <- sat(y + step(a-b)); residual is max |a-b| clamped.
  task automatic model_iter(input bit clr);
    longint d;
    longint step;
    longint mx;
    mx = 0;
    for (int e = 0; e < NUM_ELEMS; e++) begin
      if (clr) mdl[e] = 0;
      d = longint'(sa[e]) - longint'(sb[e]);
`ifdef DUAL_UPDATE_RHO_EN
      step = (longint'(rho) * d) >>> FRAC;
`else
      step = d;
`endif
      mdl[e]   = int'(sat_w(longint'(mdl[e]) + step));
      exp_d[e] = mdl[e];
      if (d < 0) d = -d;
      if (d > mx) mx = d;
    end
    exp_res = int'(sat_w(mx));
  endtask

  task automatic rand_stim();
    for (int e = 0; e < NUM_ELEMS; e++) begin
      sa[e] = int'($signed(W'($urandom)));
      sb[e] = int'($signed(W'($urandom)));
    end
  endtask

  task automatic zero_stim();
    for (int e = 0; e < NUM_ELEMS; e++) begin
      sa[e] = 0;
      sb[e] = 0;
    end
  endtask

  // mode 0: full rate; mode 1: random valid/ready plus ignored start/clear pokes;
  // mode 2: five-cycle output stall while the second beat is offered.
  task automatic run_iter(input bit clr, input int mode);
    int in_k;
    int out_k;
    bit stalled;
    bit last_acc;
    bit finished;
    bit early_done;
    logic [LANES-1:0][W-1:0] held;
    model_iter(clr);
    in_k = 0;
    out_k = 0;
    stalled = 1'b0;
    last_acc = 1'b0;
    finished = 1'b0;
    early_done = 1'b0;
    held = '0;
    @(negedge clk);
    start = 1'b1;
    clear_duals = clr;
    @(negedge clk);
    start = 1'b0;
    clear_duals = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (mode == 2) begin
        bus.in_valid  = (in_k < BEATS) && (in_k == 0 || cyc >= 3);
        bus.out_ready = !(cyc >= 2 && cyc <= 6);
      end else if (mode == 1) begin
        bus.in_valid  = (in_k < BEATS) && ($urandom_range(0, 2) != 0);
        bus.out_ready = ($urandom_range(0, 3) != 0);
        start         = (out_k < BEATS) && ($urandom_range(0, 4) == 0);
        clear_duals   = (out_k < BEATS) && ($urandom_range(0, 4) == 0);
      end else begin
        bus.in_valid  = (in_k < BEATS);
        bus.out_ready = 1'b1;
      end
      for (int j = 0; j < LANES; j++) begin
        if (in_k < BEATS) begin
          bus.in_a[j] = W'(sa[in_k * LANES + j]);
          bus.in_b[j] = W'(sb[in_k * LANES + j]);
        end else begin
          bus.in_a[j] = '0;
          bus.in_b[j] = '0;
        end
      end
      #1;
      if (last_acc) begin
        check_val("done_pulse", done, 1);
        check_val("resid_max", resid_max, exp_res);
        check_val("busy_after", busy, 0);
        check_val("no_extra_beat", bus.out_valid, 0);
        finished = 1'b1;
      end else begin
        if (done) early_done = 1'b1;
        if (stalled) begin
          check_val("stall_valid", bus.out_valid, 1);
          check_val("stall_hold", longint'(bus.out_dual), longint'(held));
        end
        stalled = 1'b0;
        if (bus.out_valid && bus.out_ready) begin
          for (int j = 0; j < LANES; j++) begin
            got_d[out_k * LANES + j] = int'($signed(bus.out_dual[j]));
            check_val($sformatf("dual_e%0d", out_k * LANES + j),
                      $signed(bus.out_dual[j]), exp_d[out_k * LANES + j]);
          end
          check_val($sformatf("last_b%0d", out_k), bus.out_last, (out_k == BEATS - 1));
          out_k++;
          if (out_k == BEATS) last_acc = 1'b1;
        end else if (bus.out_valid) begin
          check_val("in_ready_stall", bus.in_ready, 0);
          held = bus.out_dual;
          stalled = 1'b1;
        end
        if (bus.in_valid && bus.in_ready) in_k++;
      end
      if (!finished) @(negedge clk);
    end
    start = 1'b0;
    clear_duals = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check_val("iter_complete", finished, 1);
    check_val("done_not_early", early_done, 0);
    @(negedge clk);
    #1;
    check_val("done_one_cycle", done, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_a = '0;
    bus.in_b = '0;
    for (int e = 0; e < NUM_ELEMS; e++) mdl[e] = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b1;
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_out_valid", bus.out_valid, 0);
    check_val("rst_out_last", bus.out_last, 0);
    check_val("rst_resid", resid_max, 0);
    check_val("idle_in_ready", bus.in_ready, 0);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b0;

    // basic
    zero_stim();
    sa[0] = 10; sa[1] = 20; sa[2] = 30; sa[3] = 40;
    sb[0] = 1;  sb[1] = 2;  sb[2] = 3;  sb[3] = 4;
    run_iter(1'b1, 0);
    check_val("basic_e0", got_d[0], 9);
    check_val("basic_e3", got_d[3], 36);
    check_val("basic_e4", got_d[4], 0);
    check_val("basic_resid", resid_max, 36);

    // accumulation
    run_iter(1'b0, 0);
    check_val("accum_e1", got_d[1], 36);
    check_val("accum_e3", got_d[3], 72);

    // saturation
    zero_stim();
    sa[0] = 32760; sa[1] = -32760;
    run_iter(1'b1, 0);
    zero_stim();
    sa[0] = 100; sa[1] = -100; sa[2] = 32767; sb[2] = -32768;
    run_iter(1'b0, 0);
    check_val("sat_hi", got_d[0], 32767);
    check_val("sat_lo", got_d[1], -32768);
    check_val("sat_resid", resid_max, 32767);

    // backpressure, then read back the register file with a zero-step pass
    rand_stim();
    run_iter(1'b1, 2);
    zero_stim();
    run_iter(1'b0, 0);

    // randomized iterations with random stalls and ignored control pokes
    for (int it = 0; it < 8; it++) begin
      rand_stim();
      run_iter(1'($urandom_range(0, 1)), 1);
    end

    // clear together with start gives a-b directly
    rand_stim();
    run_iter(1'b1, 1);
    check_val("clr_start_e0", got_d[0], sat_w(longint'(sa[0]) - longint'(sb[0])));

    // reset in the middle of a run
    rand_stim();
    run_iter(1'b0, 0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rand_stim();
    bus.in_valid = 1'b1;
    for (int j = 0; j < LANES; j++) begin
      bus.in_a[j] = W'(sa[j]);
      bus.in_b[j] = W'(sb[j]);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_out_valid", bus.out_valid, 0);
    check_val("midrst_resid", resid_max, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < NUM_ELEMS; e++) mdl[e] = 0;
    #1;
    check_val("postrst_done", done, 0);
    check_val("postrst_busy", busy, 0);
    rand_stim();
    run_iter(1'b0, 0);

`ifdef DUAL_UPDATE_RHO_EN
    rho = 16'h0080;
    zero_stim();
    sa[0] = 10; sa[1] = -3;
    run_iter(1'b1, 0);
    check_val("rho_half", got_d[0], 5);
    check_val("rho_floor", got_d[1], -2);
    rand_stim();
    rho = W'($urandom);
    run_iter(1'b0, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
